// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: control/ADC/DAC register bank with auto-incrementing pointer and req/ack bus.
// Optional DAC_SHADOW_EN: DAC writes land in shadows, committed to dac_out via address N_REG.
module i2c_reg_bank #(
  parameter int N_CTRL = 3,
  parameter int N_ADC  = 3,
  parameter int N_DAC  = 31,
  parameter int DW     = 8,
  parameter int AW     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_ADC-1:0][DW-1:0] adc_in,
  input  logic                     adc_valid,
  output logic [N_DAC-1:0][DW-1:0] dac_out,
  output logic [N_CTRL-1:0][2:0]   cs_control,
  output logic [N_CTRL-1:0]        cp_reset,
  output logic [N_CTRL-1:0]        timer_fen,
  output logic [N_CTRL-1:0]        timer_en,
  output logic [N_CTRL-1:0]        amp_en,
  input  logic [AW-1:0]            bus_addr,
  input  logic                     bus_addr_ld,
  input  logic [DW-1:0]            bus_wdata,
  input  logic                     bus_wr,
  input  logic                     bus_rd,
  output logic [DW-1:0]            bus_rdata,
  output logic                     bus_ack,
  output logic                     bus_err,
  output logic                     bus_busy
);
  localparam int N_REG  = N_CTRL + N_ADC + N_DAC;
  localparam int DAC_LO = N_CTRL + N_ADC;
`ifdef DAC_SHADOW_EN
  localparam int N_VALID = N_REG + 1;
`else
  localparam int N_VALID = N_REG;
`endif
  localparam logic [AW-1:0] A_ADC  = AW'(N_CTRL);
  localparam logic [AW-1:0] A_DAC  = AW'(DAC_LO);
  localparam logic [AW-1:0] A_NREG = AW'(N_REG);
  localparam logic [AW-1:0] A_LAST = AW'(N_VALID - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] regs_q [N_REG];
  logic [DW-1:0] rdata_q, rdata_d, rd_val;
  logic          op_wr_q, op_bad_q, acc_err_q, acc_err_d, ack_q, err_q;
  logic          idle, req, ld_ok, ld_bad, exec_ok, is_adc, wr_en;

  assign idle    = state_q == IDLE;
  assign req     = idle && !bus_addr_ld && (bus_wr || bus_rd);
  assign ld_ok   = idle && bus_addr_ld && bus_addr <= A_LAST;
  assign ld_bad  = idle && bus_addr_ld && bus_addr > A_LAST;
  // a simultaneous wr+rd is a rejected access: no register change, pointer holds
  assign exec_ok = state_q == EXEC && !op_bad_q;
  assign is_adc  = ptr_q >= A_ADC && ptr_q < A_DAC;
  assign wr_en   = exec_ok && op_wr_q && !is_adc && ptr_q < A_NREG;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_REG; i++) rd_val = ptr_q == AW'(i) ? regs_q[i] : rd_val;
    state_d   = idle ? (req ? EXEC : IDLE) : state_q == EXEC ? RESP : IDLE;
    ptr_d     = ld_ok ? bus_addr : exec_ok ? (ptr_q == A_LAST ? '0 : ptr_q + AW'(1)) : ptr_q;
    rdata_d   = exec_ok && !op_wr_q ? rd_val : rdata_q;
    acc_err_d = state_q == EXEC ? op_bad_q || (op_wr_q && is_adc) : acc_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rdata_q   <= '0;
      acc_err_q <= 1'b0;
      op_wr_q   <= 1'b0;
      op_bad_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      acc_err_q <= acc_err_d;
      if (req) begin
        op_wr_q  <= bus_wr;
        op_bad_q <= bus_wr && bus_rd;
      end
      ack_q <= state_q == RESP;
      err_q <= state_q == RESP ? acc_err_q : ld_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) if (wr_en && ptr_q == AW'(i)) regs_q[i] <= bus_wdata;
      if (adc_valid) for (int j = 0; j < N_ADC; j++) regs_q[N_CTRL + j] <= adc_in[j];
    end
  end

  for (genvar c = 0; c < N_CTRL; c++) begin : g_ctrl
    assign cs_control[c] = regs_q[c][2:0];
    assign cp_reset[c]   = regs_q[c][3];
    assign timer_fen[c]  = regs_q[c][4];
    assign timer_en[c]   = regs_q[c][5];
    assign amp_en[c]     = regs_q[c][6];
  end

`ifdef DAC_SHADOW_EN
  logic [N_DAC-1:0][DW-1:0] dac_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dac_q <= '0;
    else if (exec_ok && op_wr_q && ptr_q == A_NREG && bus_wdata[0])
      for (int j = 0; j < N_DAC; j++) dac_q[j] <= regs_q[DAC_LO + j];
  end
  assign dac_out = dac_q;
`else
  for (genvar d = 0; d < N_DAC; d++) begin : g_dac
    assign dac_out[d] = regs_q[DAC_LO + d];
  end
`endif

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign bus_err   = err_q;
  assign bus_busy  = !idle;
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed sequences, a vector table and random traffic checked
// against an array-based model of the register map, pointer and DAC outputs.
module tb_i2c_reg_bank;
  localparam int N_CTRL = 3, N_ADC = 3, N_DAC = 31, DW = 8, AW = 6;
  localparam int N_REG  = N_CTRL + N_ADC + N_DAC;
  localparam int DAC_LO = N_CTRL + N_ADC;
`ifdef DAC_SHADOW_EN
  localparam int N_VALID = N_REG + 1;
`else
  localparam int N_VALID = N_REG;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N_ADC-1:0][DW-1:0] adc_in = '0;
  logic adc_valid = 1'b0;
  logic [N_DAC-1:0][DW-1:0] dac_out;
  logic [N_CTRL-1:0][2:0] cs_control;
  logic [N_CTRL-1:0] cp_reset, timer_fen, timer_en, amp_en;
  logic [AW-1:0] bus_addr = '0;
  logic bus_addr_ld = 1'b0, bus_wr = 1'b0, bus_rd = 1'b0;
  logic [DW-1:0] bus_wdata = '0;
  logic [DW-1:0] bus_rdata;
  logic bus_ack, bus_err, bus_busy;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m [N_REG];
  logic [DW-1:0] m_dac [N_DAC];
  int m_ptr;

  typedef struct {
    int            addr;
    bit            wr;
    bit [DW-1:0]   data;
    bit [DW-1:0]   exp_rd;
    bit            exp_err;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  i2c_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .adc_in(adc_in), .adc_valid(adc_valid), .dac_out(dac_out),
    .cs_control(cs_control), .cp_reset(cp_reset), .timer_fen(timer_fen), .timer_en(timer_en),
    .amp_en(amp_en), .bus_addr(bus_addr), .bus_addr_ld(bus_addr_ld), .bus_wdata(bus_wdata),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .bus_busy(bus_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < N_REG; i++) m[i] = '0;
    for (int j = 0; j < N_DAC; j++) m_dac[j] = '0;
    m_ptr = 0;
  endtask

  task automatic m_write(input logic [DW-1:0] d, output logic e);
    e = m_ptr >= N_CTRL && m_ptr < DAC_LO;
    if (!e && m_ptr < N_REG) m[m_ptr] = d;
`ifdef DAC_SHADOW_EN
    if (m_ptr == N_REG && d[0]) for (int j = 0; j < N_DAC; j++) m_dac[j] = m[DAC_LO + j];
`else
    if (m_ptr >= DAC_LO) m_dac[m_ptr - DAC_LO] = d;
`endif
    m_ptr = (m_ptr + 1) % N_VALID;
  endtask

  task automatic m_read(output logic [DW-1:0] v);
    v = m_ptr < N_REG ? m[m_ptr] : '0;
    m_ptr = (m_ptr + 1) % N_VALID;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < N_CTRL; i++)
      chk($sformatf("%s ctrl[%0d]", tag, i),
          {amp_en[i], timer_en[i], timer_fen[i], cp_reset[i], cs_control[i]}, m[i][6:0]);
    for (int j = 0; j < N_DAC; j++) chk($sformatf("%s dac_out[%0d]", tag, j), dac_out[j], m_dac[j]);
  endtask

  // returns with the ack cycle current; lat = cycles from the request edge to ack (0 = none)
  task automatic acc(input logic wr, input logic rd, input logic [DW-1:0] d,
                     output logic [DW-1:0] rdat, output logic err, output int lat);
    bus_wr = wr;
    bus_rd = rd;
    bus_wdata = d;
    tick;
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    lat = 0;
    rdat = '0;
    err = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (bus_ack) begin
        lat = i;
        rdat = bus_rdata;
        err = bus_err;
        break;
      end
    end
  endtask

  task automatic do_ld(input int a);
    bus_addr = AW'(a);
    bus_addr_ld = 1'b1;
    tick;
    bus_addr_ld = 1'b0;
    chk($sformatf("ld_err@%0d", a), bus_err, a >= N_VALID);
    if (a < N_VALID) m_ptr = a;
  endtask

  task automatic do_wr(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic e, ee;
    int lat, p;
    p = m_ptr;
    acc(1'b1, 1'b0, d, r, e, lat);
    m_write(d, ee);
    chk($sformatf("wr_lat@%0d", p), lat, 2);
    chk($sformatf("wr_err@%0d", p), e, ee);
  endtask

  task automatic do_rd;
    logic [DW-1:0] r, er;
    logic e;
    int lat, p;
    p = m_ptr;
    acc(1'b0, 1'b1, '0, r, e, lat);
    m_read(er);
    chk($sformatf("rd_lat@%0d", p), lat, 2);
    chk($sformatf("rd_err@%0d", p), e, 1'b0);
    chk($sformatf("rd_data@%0d", p), r, er);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] r;
    logic e, ee;
    int lat;
    model_reset();
    tick;
    tick;
    chk("rst ack", bus_ack, 0);
    chk("rst err", bus_err, 0);
    chk("rst busy", bus_busy, 0);
    chk("rst rdata", bus_rdata, 0);
    check_outputs("rst");
    rst_n = 1'b1;
    tick;

    do_rd();
    chk("amp_en0 after reset", amp_en[0], 0);
    tick;
    chk("ack one cycle", bus_ack, 0);

    do_ld(0);
    bus_wdata = 8'h7D;
    bus_wr = 1'b1;
    tick;
    bus_wr = 1'b0;
    chk("busy in exec", bus_busy, 1);
    tick;
    chk("amp_en0 at n+1", amp_en[0], 1);
    chk("no ack at n+1", bus_ack, 0);
    tick;
    chk("ack at n+2", bus_ack, 1);
    chk("err at n+2", bus_err, 0);
    m_write(8'h7D, ee);
    chk("cs_control0", cs_control[0], 5);
    chk("cp_reset0", cp_reset[0], 1);
    chk("timer_fen0", timer_fen[0], 1);
    chk("timer_en0", timer_en[0], 1);
    check_outputs("w7d");
    do_wr(8'h02);
    chk("ptr advanced to 1", cs_control[1], 2);

    adc_in[1] = 8'hA5;
    adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
    for (int j = 0; j < N_ADC; j++) m[N_CTRL + j] = adc_in[j];
    do_ld(N_CTRL + 1);
    do_rd();
    do_ld(N_CTRL + 1);
    do_wr(8'h11);
    do_ld(N_CTRL + 1);
    do_rd();
    adc_in[1] = 8'h3C;
    do_ld(N_CTRL + 1);
    bus_rd = 1'b1;
    tick;
    bus_rd = 1'b0;
    adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
    tick;
    chk("snapshot ack", bus_ack, 1);
    chk("snapshot pre-sample", bus_rdata, 8'hA5);
    m_read(r);
    m[N_CTRL + 1] = 8'h3C;
    do_ld(N_CTRL + 1);
    do_rd();

    do_ld(N_REG - 1);
    do_wr(8'h33);
`ifndef DAC_SHADOW_EN
    chk("dac_out30", dac_out[N_DAC - 1], 8'h33);
`endif
    do_wr(8'h44);
    do_ld(0);
    do_rd();
    do_ld(N_VALID);
    tick;
    chk("ld err pulse", bus_err, 0);
    do_rd();

    do_ld(7);
    bus_wdata = 8'h12;
    bus_wr = 1'b1;
    tick;
    bus_wr = 1'b0;
    tick;
    bus_wr = 1'b1;
    tick;
    bus_wr = 1'b0;
    chk("busy wr ack", bus_ack, 1);
    m_write(8'h12, ee);
    tick;
    chk("busy wr ignored busy", bus_busy, 0);
    tick;
    chk("busy wr ignored ack", bus_ack, 0);

    do_ld(7);
    acc(1'b1, 1'b1, 8'hEE, r, e, lat);
    chk("dual lat", lat, 2);
    chk("dual err", e, 1);
    do_rd();

    bus_addr = AW'(9);
    bus_addr_ld = 1'b1;
    bus_wdata = 8'h55;
    bus_wr = 1'b1;
    tick;
    bus_addr_ld = 1'b0;
    bus_wr = 1'b0;
    m_ptr = 9;
    chk("ld beats req busy", bus_busy, 0);
    tick;
    chk("ld beats req ack", bus_ack, 0);
    do_rd();

    tbl[0] = '{2,  1'b1, 8'h6A, 8'h00, 1'b0};
    tbl[1] = '{2,  1'b0, 8'h00, 8'h6A, 1'b0};
    tbl[2] = '{3,  1'b1, 8'h11, 8'h00, 1'b1};
    tbl[3] = '{3,  1'b0, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{5,  1'b0, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{10, 1'b1, 8'hF0, 8'h00, 1'b0};
    tbl[6] = '{10, 1'b0, 8'h00, 8'hF0, 1'b0};
    tbl[7] = '{20, 1'b1, 8'h0F, 8'h00, 1'b0};
    tbl[8] = '{20, 1'b0, 8'h00, 8'h0F, 1'b0};
    tbl[9] = '{11, 1'b0, 8'h00, 8'h00, 1'b0};
    for (int k = 0; k < 10; k++) begin
      do_ld(tbl[k].addr);
      acc(tbl[k].wr, !tbl[k].wr, tbl[k].data, r, e, lat);
      chk($sformatf("tbl%0d lat", k), lat, 2);
      chk($sformatf("tbl%0d err", k), e, tbl[k].exp_err);
      if (!tbl[k].wr) chk($sformatf("tbl%0d rdata", k), r, tbl[k].exp_rd);
      if (tbl[k].wr) m_write(tbl[k].data, ee);
      else m_read(r);
    end

    do_ld(12);
    bus_wdata = 8'h77;
    bus_wr = 1'b1;
    tick;
    bus_wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst busy", bus_busy, 0);
    chk("mid rst ack", bus_ack, 0);
    chk("mid rst rdata", bus_rdata, 0);
    tick;
    tick;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mid rst no ack", bus_ack, 0);
    end
    check_outputs("mid rst");
    do_ld(12);
    do_rd();

`ifdef DAC_SHADOW_EN
    do_ld(DAC_LO);
    do_wr(8'h80);
    chk("shadow dac0 held", dac_out[0], 0);
    do_ld(N_REG);
    do_rd();
    do_ld(N_REG);
    do_wr(8'h01);
    chk("commit dac0", dac_out[0], 8'h80);
`endif

    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 2) do_ld($urandom_range(0, N_VALID + 2));
      else if (op < 5) do_wr(DW'($urandom));
      else if (op < 8) do_rd();
      else if (op == 8) begin
        for (int j = 0; j < N_ADC; j++) adc_in[j] = DW'($urandom);
        adc_valid = 1'b1;
        tick;
        adc_valid = 1'b0;
        for (int j = 0; j < N_ADC; j++) m[N_CTRL + j] = adc_in[j];
      end else begin
        acc(1'b1, 1'b1, DW'($urandom), r, e, lat);
        chk("rnd dual lat", lat, 2);
        chk("rnd dual err", e, 1);
      end
      if (it % 25 == 24) check_outputs($sformatf("rnd%0d", it));
    end
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
